bilinear_coord_gen: RTL and testbench

Output-raster scanner for the bilinear scaler. It walks every destination pixel of a frame. For each one it produces the top-left source coordinate (x0, y0) and the four fixed-point interpolation weights w00/w01/w10/w11. The pixel-fetch stage consumes these, reads the four neighbours, and forwards them with the weights to the bilinear arithmetic stage, whose output is data × weight >> FIX_WIDTH with rounding.

---
 rtl/bilinear_coord_gen.sv | 237 +++++++++++++++++++++++
 tb/tb_bilinear_coord_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bilinear_coord_gen.sv
`timescale 1ns / 1ps
// bilinear_coord_gen: output-raster scanner for the bilinear scaler.
// Walks every destination pixel of a frame. For each one it emits the clamped top-left
// source coordinate (src_x_o, src_y_o) and the four fixed-point interpolation weights.
//
// Ports:
//   clk_i, rst_i                clock, asynchronous active-high reset
//   start_i                     frame start pulse, honoured only in idle
//   src_w_i, src_h_i            source dimensions (>= 1), latched at start
//   dst_w_i, dst_h_i            destination dimensions, latched at start
//   step_x_i, step_y_i          source step per destination pixel (H fractional bits)
//   busy_o, done_o              frame in progress / one-cycle completion pulse
//   tvalid_o, tready_i          beat handshake
//   src_x_o, src_y_o            clamped x0, y0
//   weight00_o .. weight11_o    interpolation weights, FIX_WIDTH bits
//   tuser_o, tlast_o            first beat of frame / last beat of row
module bilinear_coord_gen #(
  parameter int unsigned COORD_WIDTH = 12,
  parameter int unsigned FIX_WIDTH   = 12
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               start_i,
  input  logic [COORD_WIDTH-1:0]             src_w_i,
  input  logic [COORD_WIDTH-1:0]             src_h_i,
  input  logic [COORD_WIDTH-1:0]             dst_w_i,
  input  logic [COORD_WIDTH-1:0]             dst_h_i,
  input  logic [COORD_WIDTH+FIX_WIDTH/2-1:0] step_x_i,
  input  logic [COORD_WIDTH+FIX_WIDTH/2-1:0] step_y_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               tvalid_o,
  input  logic                               tready_i,
  output logic [COORD_WIDTH-1:0]             src_x_o,
  output logic [COORD_WIDTH-1:0]             src_y_o,
  output logic [FIX_WIDTH-1:0]               weight00_o,
  output logic [FIX_WIDTH-1:0]               weight01_o,
  output logic [FIX_WIDTH-1:0]               weight10_o,
  output logic [FIX_WIDTH-1:0]               weight11_o,
  output logic                               tuser_o,
  output logic                               tlast_o
);

  localparam int unsigned H     = FIX_WIDTH / 2;
  localparam int unsigned StepW = COORD_WIDTH + H;
  localparam int unsigned AccW  = COORD_WIDTH + H + 1;

  localparam logic [COORD_WIDTH-1:0] CoordOne = {{(COORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [H:0]             OneH     = {1'b1, {H{1'b0}}};

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e state_q, state_d;

  // Frame parameters latched at start
  logic [COORD_WIDTH-1:0] src_w_q, src_h_q, dst_w_q, dst_h_q;
  logic [StepW-1:0]       step_x_q, step_y_q;

  // Generator position: describes the next beat to be loaded into the output register
  logic [COORD_WIDTH-1:0] dx_q, dy_q;
  logic [AccW-1:0]        acc_x_q, acc_y_q;
  logic                   gen_pend_q;

  // Output register
  logic                   tvalid_q, tuser_q, tlast_q, final_q;
  logic [COORD_WIDTH-1:0] src_x_q, src_y_q;
  logic [FIX_WIDTH-1:0]   w00_q, w01_q, w10_q, w11_q;

  // ---------------------------------------------------------------------------------------
  // Coordinate mapping and weights for the generator position
  // ---------------------------------------------------------------------------------------
  logic [COORD_WIDTH:0]   ix, iy;
  logic [COORD_WIDTH-1:0] src_w_m1, src_h_m1, x0, y0;
  logic [H-1:0]           fx, fy;
  logic [H:0]             ax, ay;
  logic [FIX_WIDTH+1:0]   p00, p01, p10, p11;

  function automatic logic [FIX_WIDTH-1:0] sat_w(input logic [FIX_WIDTH+1:0] p);
    // Only 2^FIX_WIDTH (w00 at fx=fy=0) can exceed the range
    return (|p[FIX_WIDTH+1:FIX_WIDTH]) ? {FIX_WIDTH{1'b1}} : p[FIX_WIDTH-1:0];
  endfunction

  always_comb begin
    src_w_m1 = src_w_q - CoordOne;
    src_h_m1 = src_h_q - CoordOne;
    ix       = acc_x_q[AccW-1:H];
    iy       = acc_y_q[AccW-1:H];
    x0       = ix[COORD_WIDTH-1:0];
    y0       = iy[COORD_WIDTH-1:0];
    fx       = acc_x_q[H-1:0];
    fy       = acc_y_q[H-1:0];
    // Past the right/bottom edge: pin to the last pixel with no fractional part
    if (ix > {1'b0, src_w_m1}) begin
      x0 = src_w_m1;
      fx = '0;
    end
    if (iy > {1'b0, src_h_m1}) begin
      y0 = src_h_m1;
      fy = '0;
    end
    ax  = OneH - {1'b0, fx};
    ay  = OneH - {1'b0, fy};
    p00 = {{(H+1){1'b0}}, ax} * {{(H+1){1'b0}}, ay};
    p01 = {{(H+2){1'b0}}, fx} * {{(H+1){1'b0}}, ay};
    p10 = {{(H+1){1'b0}}, ax} * {{(H+2){1'b0}}, fy};
    p11 = {{(H+2){1'b0}}, fx} * {{(H+2){1'b0}}, fy};
  end

  // ---------------------------------------------------------------------------------------
  // Handshake and position flags
  // ---------------------------------------------------------------------------------------
  logic load, accept, first_beat, row_end, frame_end, zero_size;

  always_comb begin
    accept     = tvalid_q & tready_i;
    load       = (state_q == StRun) & gen_pend_q & (~tvalid_q | tready_i);
    first_beat = (dx_q == '0) & (dy_q == '0);
    row_end    = (dx_q == dst_w_q - CoordOne);
    frame_end  = row_end & (dy_q == dst_h_q - CoordOne);
    zero_size  = (dst_w_q == '0) | (dst_h_q == '0);
  end

  // ---------------------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = StLoad;
      StLoad: state_d = zero_size ? StDone : StRun;
      StRun:  if (accept && final_q) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Parameter latch and generator
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_w_q    <= '0;
      src_h_q    <= '0;
      dst_w_q    <= '0;
      dst_h_q    <= '0;
      step_x_q   <= '0;
      step_y_q   <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      gen_pend_q <= 1'b0;
    end else begin
      if (state_q == StIdle && start_i) begin
        src_w_q  <= src_w_i;
        src_h_q  <= src_h_i;
        dst_w_q  <= dst_w_i;
        dst_h_q  <= dst_h_i;
        step_x_q <= step_x_i;
        step_y_q <= step_y_i;
      end
      if (state_q == StLoad) begin
        dx_q       <= '0;
        dy_q       <= '0;
        acc_x_q    <= '0;
        acc_y_q    <= '0;
        gen_pend_q <= ~zero_size;
      end else if (load) begin
        if (row_end) begin
          dx_q    <= '0;
          dy_q    <= dy_q + CoordOne;
          acc_x_q <= '0;
          acc_y_q <= acc_y_q + {1'b0, step_y_q};
        end else begin
          dx_q    <= dx_q + CoordOne;
          acc_x_q <= acc_x_q + {1'b0, step_x_q};
        end
        if (frame_end) gen_pend_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Output register: holds while stalled, reloads on a free slot
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      final_q  <= 1'b0;
      src_x_q  <= '0;
      src_y_q  <= '0;
      w00_q    <= '0;
      w01_q    <= '0;
      w10_q    <= '0;
      w11_q    <= '0;
    end else if (load) begin
      tvalid_q <= 1'b1;
      tuser_q  <= first_beat;
      tlast_q  <= row_end;
      final_q  <= frame_end;
      src_x_q  <= x0;
      src_y_q  <= y0;
      w00_q    <= sat_w(p00);
      w01_q    <= sat_w(p01);
      w10_q    <= sat_w(p10);
      w11_q    <= sat_w(p11);
    end else if (accept) begin
      tvalid_q <= 1'b0;
      final_q  <= 1'b0;
    end
  end

  always_comb begin
    busy_o     = (state_q != StIdle);
    done_o     = (state_q == StDone);
    tvalid_o   = tvalid_q;
    tuser_o    = tuser_q;
    tlast_o    = tlast_q;
    src_x_o    = src_x_q;
    src_y_o    = src_y_q;
    weight00_o = w00_q;
    weight01_o = w01_q;
    weight10_o = w10_q;
    weight11_o = w11_q;
  end

endmodule

// File: tb/tb_bilinear_coord_gen.sv
`timescale 1ns / 1ps
// Directed bench for bilinear_coord_gen (COORD_WIDTH=12, FIX_WIDTH=12, H=6).
module tb_bilinear_coord_gen;

  logic        clk = 1'b0;
  logic        rst, start, tready;
  logic [11:0] src_w, src_h, dst_w, dst_h;
  logic [17:0] step_x, step_y;
  logic        busy, done, tvalid, tuser, tlast;
  logic [11:0] src_x, src_y, w00, w01, w10, w11;

  int n_tests = 0;
  int n_fail  = 0;

  // Parameters of the frame currently expected
  int cur_sw, cur_sh, cur_stx, cur_sty;

  bilinear_coord_gen #(
    .COORD_WIDTH(12),
    .FIX_WIDTH  (12)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .src_w_i   (src_w),
    .src_h_i   (src_h),
    .dst_w_i   (dst_w),
    .dst_h_i   (dst_h),
    .step_x_i  (step_x),
    .step_y_i  (step_y),
    .busy_o    (busy),
    .done_o    (done),
    .tvalid_o  (tvalid),
    .tready_i  (tready),
    .src_x_o   (src_x),
    .src_y_o   (src_y),
    .weight00_o(w00),
    .weight01_o(w01),
    .weight10_o(w10),
    .weight11_o(w11),
    .tuser_o   (tuser),
    .tlast_o   (tlast)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] out_vec();
    return {busy, done, tvalid, tuser, tlast, src_x, src_y, w00, w01, w10, w11};
  endfunction

  // Reference mapping: position computed directly as d*step, not by accumulation
  task automatic model(input int dx, input int dy, output int x0, output int y0,
                       output int e00, output int e01, output int e10, output int e11);
    int ax_acc, ay_acc, fx, fy, ax, ay;
    ax_acc = (dx * cur_stx) % (1 << 19);
    ay_acc = (dy * cur_sty) % (1 << 19);
    x0 = ax_acc >> 6;
    fx = ax_acc % 64;
    y0 = ay_acc >> 6;
    fy = ay_acc % 64;
    if (x0 > cur_sw - 1) begin x0 = cur_sw - 1; fx = 0; end
    if (y0 > cur_sh - 1) begin y0 = cur_sh - 1; fy = 0; end
    ax  = 64 - fx;
    ay  = 64 - fy;
    e00 = ax * ay;
    e01 = fx * ay;
    e10 = ax * fy;
    e11 = fx * fy;
    if (e00 == 4096) e00 = 4095;
  endtask

  task automatic start_frame(input int sw, input int sh, input int dw, input int dh,
                             input int stx, input int sty);
    src_w  = 12'(sw);
    src_h  = 12'(sh);
    dst_w  = 12'(dw);
    dst_h  = 12'(dh);
    step_x = 18'(stx);
    step_y = 18'(sty);
    cur_sw = sw; cur_sh = sh; cur_stx = stx; cur_sty = sty;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Runs one non-empty frame; rnd selects 50% tready, mid pulses start_i mid-frame
  task automatic run_frame(input string nm, input int sw, input int sh, input int dw,
                           input int dh, input int stx, input int sty, input int rnd,
                           input int mid);
    int beats, cyc, edx, edy, x0, y0, e00, e01, e10, e11, total;
    logic prev_stall;
    logic [127:0] prev_vec;
    total = dw * dh;
    tready = 1'b1;
    start_frame(sw, sh, dw, dh, stx, sty);
    check({nm, "_busy_n1"}, {busy, tvalid}, 2'b10);
    tick();
    check({nm, "_novalid_n2"}, tvalid, 1'b0);
    tick();
    check({nm, "_valid_n3"}, tvalid, 1'b1);
    beats = 0; cyc = 0; edx = 0; edy = 0; prev_stall = 1'b0; prev_vec = '0;
    while (beats < total && cyc < 4000) begin
      tready = rnd != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall) check({nm, "_stall_hold"}, out_vec(), prev_vec);
      if (mid != 0 && cyc == 10) begin
        // Must be ignored: different dimensions and steps
        start = 1'b1; dst_w = 12'd2; dst_h = 12'd2; step_x = 18'd0; step_y = 18'd0;
      end else begin
        start = 1'b0;
      end
      if (tvalid && tready) begin
        model(edx, edy, x0, y0, e00, e01, e10, e11);
        check({nm, "_beat"}, {src_x, src_y, w00, w01, w10, w11, tuser, tlast},
              {12'(x0), 12'(y0), 12'(e00), 12'(e01), 12'(e10), 12'(e11),
               1'(edx == 0 && edy == 0), 1'(edx == dw - 1)});
        if (dw == 8 && dh == 8 && edx == 0 && edy == 0)
          check({nm, "_b00"}, {src_x, src_y, w00, w01, w10, w11, tuser},
                {12'd0, 12'd0, 12'd4095, 12'd0, 12'd0, 12'd0, 1'b1});
        if (dw == 8 && dh == 8 && edx == 1 && edy == 0)
          check({nm, "_b10"}, {src_x, w00, w01, w10, w11},
                {12'd0, 12'd2048, 12'd2048, 12'd0, 12'd0});
        if (dw == 8 && dh == 8 && edx == 7 && edy == 7)
          check({nm, "_b77"}, {src_x, src_y, w00, w01, w10, w11, tlast},
                {12'd3, 12'd3, 12'd1024, 12'd1024, 12'd1024, 12'd1024, 1'b1});
        if (dw == 3 && edx == 2)
          check({nm, "_clamp"}, {src_x, src_y, w00, w01, w10, w11, tlast},
                {12'd3, 12'd0, 12'd4095, 12'd0, 12'd0, 12'd0, 1'b1});
        beats++;
        if (edx == dw - 1) begin edx = 0; edy++; end else edx++;
      end
      prev_stall = tvalid & ~tready;
      prev_vec   = out_vec();
      tick();
      cyc++;
    end
    start = 1'b0;
    check({nm, "_beats"}, beats, total);
    if (rnd == 0) check({nm, "_no_bubbles"}, cyc, total);
    check({nm, "_end_m1"}, {busy, done, tvalid}, 3'b110);
    tready = 1'b1;
    tick();
    check({nm, "_end_m2"}, {busy, done, tvalid}, 3'b000);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tready = 1'b0;
    src_w = '0; src_h = '0; dst_w = '0; dst_h = '0; step_x = '0; step_y = '0;
    cur_sw = 1; cur_sh = 1; cur_stx = 0; cur_sty = 0;
    tick();
    tick();
    check("reset_state", out_vec(), '0);
    rst = 1'b0;
    tick();
    check("idle_after_reset", out_vec(), '0);

    // 2x upscale, full throughput
    run_frame("up2x", 4, 4, 8, 8, 32, 32, 0, 0);
    // Same frame under random backpressure with an ignored mid-frame start
    run_frame("bp", 4, 4, 8, 8, 32, 32, 1, 1);
    // Right-edge clamp
    run_frame("clamp", 4, 4, 3, 1, 128, 0, 0, 0);

    // Zero-size frame
    tready = 1'b1;
    start_frame(4, 4, 0, 5, 64, 64);
    check("zero_n1", {busy, done, tvalid}, 3'b100);
    tick();
    check("zero_n2", {busy, done, tvalid}, 3'b110);
    tick();
    check("zero_n3", {busy, done, tvalid}, 3'b000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("zero_quiet", {busy, done, tvalid}, 3'b000);
    end

    // Reset mid-frame while a beat is stalled
    tready = 1'b0;
    start_frame(4, 4, 8, 8, 32, 32);
    tick();
    tick();
    tick();
    check("rstmid_valid", {busy, tvalid}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_async_clear", out_vec(), '0);
    start = 1'b1;  // coincident with reset: reset wins
    tick();
    check("rstmid_start_vs_rst", out_vec(), '0);
    start = 1'b0;
    rst = 1'b0;
    tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rstmid_quiet", {busy, done, tvalid}, 3'b000);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
